// File: rtl/ex_ctrl_pkg.sv
// Shared types and constants for the execute-stage sequencing controller.
// Used by ex_seq_ctrl (optional EX_PERF_CNT_EN counters live in the top).
package ex_ctrl_pkg;

    localparam int FUNCT_W = 3;
    localparam int STATE_W = 3;
    localparam int NUM_FUNCT = 1 << FUNCT_W;

    localparam logic [NUM_FUNCT-1:0] TWO_OP_MASK_DEF = 8'b0000_1111;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        EXEC   = 3'd2,
        DONE   = 3'd3,
        BRANCH = 3'd4
    } state_e;

    // Instruction fields captured on the accept edge.
    typedef struct packed {
        logic [FUNCT_W-1:0] funct;
        logic               j;
        logic               jc;
        logic               neq;
        logic               ina;
    } instr_t;

    function automatic logic needs_ac_in_load(input logic [NUM_FUNCT-1:0] mask,
                                              input logic [FUNCT_W-1:0]   funct);
        return mask[funct];
    endfunction

endpackage

// File: rtl/ex_branch_eval.sv
// Branch resolution: unconditional jump, or conditional jump whose polarity
// (neq) is compared against the registered zero flag.
module ex_branch_eval (
    input  logic j_i,
    input  logic jc_i,
    input  logic neq_i,
    input  logic zero_flag_i,
    output logic taken_o
);

    assign taken_o = j_i | (jc_i & (zero_flag_i ^ neq_i));

endmodule

// File: rtl/ex_seq_ctrl.sv
// Execute-stage sequencing FSM: acIn load, ALU fire, result handshake, branch.
// Define EX_PERF_CNT_EN to add saturating stall/branch performance counters.
module ex_seq_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter logic [NUM_FUNCT-1:0] TWO_OP_MASK = TWO_OP_MASK_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               j_in,
    input  logic               jc_in,
    input  logic               neq_in,
    input  logic               ina_in,
    input  logic               zero_flag,
    input  logic               mem_ready,
    output logic               stall,
    output logic               ac_in_load,
    output logic               mux_sel,
    output logic [FUNCT_W-1:0] alu_op,
    output logic               ac_out_load,
    output logic               valid_out,
    output logic               take_branch,
    output logic               flush,
    output logic               busy
`ifdef EX_PERF_CNT_EN
    ,
    output logic [15:0]        stall_cycles,
    output logic [7:0]         branch_taken_cnt
`endif
);

    state_e state_q, state_d;
    instr_t instr_q, instr_d;
    logic   taken;

    ex_branch_eval u_branch_eval (
        .j_i        (instr_q.j),
        .jc_i       (instr_q.jc),
        .neq_i      (instr_q.neq),
        .zero_flag_i(zero_flag),
        .taken_o    (taken)
    );

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // NOTE: every output gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        ac_in_load  = 1'b0;
        mux_sel     = 1'b0;
        alu_op      = '0;
        ac_out_load = 1'b0;
        valid_out   = 1'b0;
        take_branch = 1'b0;
        flush       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    instr_d = '{funct: funct, j: j_in, jc: jc_in, neq: neq_in, ina: ina_in};
                    if (j_in || jc_in) begin
                        state_d = BRANCH;
                    end else if (needs_ac_in_load(TWO_OP_MASK, funct)) begin
                        state_d = LOAD;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            LOAD: begin
                ac_in_load = 1'b1;
                mux_sel    = instr_q.ina;
                state_d    = EXEC;
            end
            EXEC: begin
                alu_op      = instr_q.funct;
                ac_out_load = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                alu_op    = instr_q.funct;
                valid_out = 1'b1;
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            BRANCH: begin
                take_branch = taken;
                flush       = taken;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy;

`ifdef EX_PERF_CNT_EN
    logic [15:0] stall_cycles_q;
    logic [7:0]  branch_taken_cnt_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cycles_q     <= '0;
            branch_taken_cnt_q <= '0;
        end else begin
            if (stall && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
            if (take_branch && (branch_taken_cnt_q != '1)) begin
                branch_taken_cnt_q <= branch_taken_cnt_q + 8'd1;
            end
        end
    end

    assign stall_cycles     = stall_cycles_q;
    assign branch_taken_cnt = branch_taken_cnt_q;
`endif

endmodule

// File: doc/ex_seq_ctrl.md
Name: ex_seq_ctrl

Overview:
Sequencing FSM for the 8-bit execute stage. It accepts one decoded instruction at a time and serialises the stage's resources:
- loads the ALU input accumulator (acIn) through the register/immediate mux;
- fires the ALU, then loads the output accumulator (acOut) and the zero register;
- resolves jumps and conditional jumps against the zero flag.

It stalls the decode stage while busy and hands results to the memory stage with a valid/ready handshake.

Parameters:
TWO_OP_MASK, 8'b0000_1111, bit i set means funct==i needs an acIn load before execute.
FUNCT_W, 3, width of the ALU function field.

Ports:
clock  in  1  stage clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
valid_in  in  1  decode presents an instruction
funct  in  FUNCT_W  ALU function code
j_in  in  1  unconditional jump
jc_in  in  1  conditional jump
neq_in  in  1  jc polarity: 0 jumps on zero=1, 1 jumps on zero=0
ina_in  in  1  acIn source: 1 immediate (sign-extended), 0 register value
zero_flag  in  1  registered zero output of the EX zero register
mem_ready  in  1  memory stage can accept a result
stall  out  1  hold decode/PC; high in every state except IDLE
ac_in_load  out  1  acIn accept strobe
mux_sel  out  1  acIn source mux select, follows latched ina
alu_op  out  FUNCT_W  latched funct to ALU control
ac_out_load  out  1  SOUT strobe: acOut and zero register accept
valid_out  out  1  result in acOut valid to memory stage
take_branch  out  1  one-cycle pulse: PC loads the jump-adder output
flush  out  1  one-cycle pulse with take_branch: kill IF/ID contents
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at a clock edge):
  - state goes to IDLE.
  - All outputs go to 0, alu_op goes to 0, and latched fields are cleared.
  - Reset in any state abandons the operation with no valid_out and no take_branch.
- States: IDLE, LOAD, EXEC, DONE, BRANCH.
- IDLE:
  - stall=0.
  - If valid_in=1, latch funct, j, jc, neq and ina.
  - Next state, by priority:
    - j_in or jc_in: BRANCH (j_in wins if both are set).
    - Else TWO_OP_MASK[funct]==1: LOAD.
    - Else: EXEC.
  - valid_in=0: stay in IDLE.
- LOAD:
  - ac_in_load=1 and mux_sel=latched ina, for exactly one cycle.
  - Next state: EXEC.
- EXEC:
  - alu_op=latched funct and ac_out_load=1, for exactly one cycle.
  - Next state: DONE.
- DONE:
  - valid_out=1 and alu_op held.
  - mem_ready=1: go to IDLE, valid_out drops next cycle.
  - mem_ready=0: hold in DONE with valid_out stable. acOut is not reloaded.
- BRANCH:
  - Condition taken = j | (jc & (zero_flag ^ neq)).
  - zero_flag is sampled in this cycle, which is the flag of the last EXEC.
  - If taken: take_branch=1 and flush=1 for one cycle.
  - Next state is always IDLE. A branch never asserts valid_out.
- Latency from the accept edge:
  - single-operand op: valid_out in cycle 2.
  - two-operand op: valid_out in cycle 3.
  - branch: take_branch in cycle 1.
  - Throughput is one instruction per (latency+1) cycles when mem_ready=1.
- valid_in while stall=1 is ignored. Decode must hold its instruction.
- ac_in_load, ac_out_load and take_branch are mutually exclusive in any cycle.
- funct outside the TWO_OP_MASK range cannot occur (FUNCT_W=3 → 8 codes).

Optional Feature:
EX_PERF_CNT_EN:
- Defined:
  - Adds output stall_cycles[15:0], which counts clocks with stall=1.
  - Adds output branch_taken_cnt[7:0], which counts take_branch pulses.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: neither port nor its logic exists, and behaviour is otherwise identical.

Decomposition:
- Package ex_ctrl_pkg holds:
  - state encoding localparams (IDLE=0, LOAD=1, EXEC=2, DONE=3, BRANCH=4, 3-bit);
  - FUNCT_W;
  - the default TWO_OP_MASK.
- One sub-module, ex_branch_eval: combinational taken computation from j, jc, neq and zero_flag, instantiated once.
- The FSM and the output decode stay in ex_seq_ctrl.

Test Plan:
1. Reset: hold reset=0 for 2 cycles in EXEC mid-operation, release → state IDLE, all outputs 0, no valid_out ever appears.
2. Two-operand op: funct=3'b001, ina=1, valid_in pulse → ac_in_load=1 with mux_sel=1 in cycle 1, ac_out_load=1 with alu_op=001 in cycle 2, valid_out=1 in cycle 3, stall=1 in cycles 1-3.
3. Single-operand op: funct=3'b101 → no ac_in_load, ac_out_load in cycle 1, valid_out in cycle 2. Hold mem_ready=0 for 4 cycles → valid_out stays 1, stall stays 1, single ac_out_load.
4. Conditional jump: jc=1, neq=0, zero_flag=1 → take_branch=flush=1 in cycle 1. Repeat with zero_flag=0 → no pulse, back to IDLE in cycle 2. Repeat with neq=1, zero_flag=0 → taken.
5. Jump priority and stall: j=1 and jc=1 with zero_flag=0 → taken. A new valid_in during BRANCH is ignored and accepted only once IDLE is reached.
6. With EX_PERF_CNT_EN: run scenario 2 then a taken jump → stall_cycles=4, branch_taken_cnt=1.
